// File: rtl/keypad_scan_pkg.sv
// Shared definitions for the keypad scanner: state encoding, line constants
// and small index/rotation helpers.
package keypad_scan_pkg;

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_PRESSED  = 2'd2,
        ST_RELEASE  = 2'd3
    } state_t;

    localparam logic [3:0] COL_IDLE   = 4'hF;
    localparam logic [3:0] ROW_NONE   = 4'hF;
    localparam logic [3:0] COL_RESET  = 4'b1110;
    localparam int         KEY_CODE_W = 4;

    // Index of the lowest zero bit; several low rows resolve to the lowest one.
    function automatic logic [1:0] low_idx(input logic [3:0] v);
        logic [1:0] idx;
        casez (v)
            4'b???0: idx = 2'd0;
            4'b??01: idx = 2'd1;
            4'b?011: idx = 2'd2;
            default: idx = 2'd3;
        endcase
        return idx;
    endfunction

    function automatic logic [3:0] rotate_col(input logic [3:0] v);
        return {v[2:0], v[3]};
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/keypad_scan_tick.sv
// Free-running divider emitting a one-clock tick every DIV clocks; the first
// tick lands DIV clocks after reset release. Shared with the display scanner.
module keypad_scan_tick #(
    parameter int DIV = 25000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    output logic o_tick
);

    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [W-1:0] r_div;
    logic         r_tick;

    // Divider and registered tick, high while the divider sits at DIV-1.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_div  <= '0;
            r_tick <= 1'b0;
        end else begin
            r_tick <= (r_div == W'(DIV - 2));
            if (r_div == W'(DIV - 1)) begin
                r_div <= '0;
            end else begin
                r_div <= r_div + W'(1);
            end
        end
    end

    assign o_tick = r_tick;

endmodule

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner with debounce and one strobe per press.
// Optional auto-repeat of the held key is enabled by defining KEYPAD_REPEAT_EN.
module keypad_scan
    import keypad_scan_pkg::*;
#(
    parameter int SCAN_DIV       = 25000,
    parameter int DEBOUNCE_TICKS = 8,
    parameter int REPEAT_TICKS   = 500
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [3:0]            row,
    output logic [3:0]            col,
    output logic [KEY_CODE_W-1:0] key_code,
    output logic                  key_valid,
    output logic                  key_down
);

    if (SCAN_DIV < 2 || DEBOUNCE_TICKS < 1 || DEBOUNCE_TICKS > 255 ||
        REPEAT_TICKS < 1 || REPEAT_TICKS > 65535) begin : g_bad_cfg
        $error("keypad_scan: parameter out of range");
    end

    localparam logic [7:0] DB_LIMIT = 8'(DEBOUNCE_TICKS);

    logic                  w_tick;
    logic [3:0]            r_sync1, r_sync2;
    state_t                r_state, w_state_n;
    logic [3:0]            r_col, w_col_n;
    logic [3:0]            r_pattern, w_pattern_n;
    logic [7:0]            r_cnt, w_cnt_n, w_cnt_inc;
    logic [KEY_CODE_W-1:0] r_code, w_code_n;
    logic                  r_valid, w_valid_n;
    logic                  r_down, w_down_n;
    logic                  w_accept;
`ifdef KEYPAD_REPEAT_EN
    localparam logic [15:0] REP_LIMIT = 16'(REPEAT_TICKS);
    logic [15:0]           r_rep, w_rep_n;
`endif

    keypad_scan_tick #(.DIV(SCAN_DIV)) u_tick (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .o_tick  (w_tick)
    );

    // Two-flop synchronizer for the asynchronous row lines.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= ROW_NONE;
            r_sync2 <= ROW_NONE;
        end else begin
            r_sync1 <= row;
            r_sync2 <= r_sync1;
        end
    end

    // Next-state and output decode; everything holds except on a tick.
    always_comb begin
        w_state_n   = r_state;
        w_col_n     = r_col;
        w_pattern_n = r_pattern;
        w_cnt_n     = r_cnt;
        w_code_n    = r_code;
        w_valid_n   = 1'b0;
        w_down_n    = r_down;
        w_accept    = 1'b0;
        w_cnt_inc   = sat_inc8(r_cnt);
`ifdef KEYPAD_REPEAT_EN
        w_rep_n     = r_rep;
`endif
        if (w_tick) begin
            case (r_state)
                ST_SCAN: begin
                    if (r_sync2 == ROW_NONE) begin
                        w_col_n = rotate_col(r_col);
                    end else begin
                        w_pattern_n = r_sync2;
                        w_cnt_n     = 8'd1;
                        if (DB_LIMIT == 8'd1) begin
                            w_accept  = 1'b1;
                            w_state_n = ST_PRESSED;
                        end else begin
                            w_state_n = ST_DEBOUNCE;
                        end
                    end
                end
                ST_DEBOUNCE: begin
                    if (r_sync2 == r_pattern) begin
                        w_cnt_n = w_cnt_inc;
                        if (w_cnt_inc >= DB_LIMIT) begin
                            w_accept  = 1'b1;
                            w_state_n = ST_PRESSED;
                        end else begin
                            w_state_n = ST_DEBOUNCE;
                        end
                    end else begin
                        w_state_n = ST_SCAN;
                        w_col_n   = rotate_col(r_col);
                        w_cnt_n   = 8'd0;
                    end
                end
                ST_PRESSED: begin
                    if (r_sync2 == ROW_NONE) begin
                        w_cnt_n = 8'd1;
                        if (DB_LIMIT == 8'd1) begin
                            w_down_n  = 1'b0;
                            w_state_n = ST_SCAN;
                            w_col_n   = rotate_col(r_col);
                            w_cnt_n   = 8'd0;
                        end else begin
                            w_state_n = ST_RELEASE;
                        end
                    end else begin
`ifdef KEYPAD_REPEAT_EN
                        if (r_rep + 16'd1 >= REP_LIMIT) begin
                            w_valid_n = 1'b1;
                            w_rep_n   = 16'd0;
                        end else begin
                            w_rep_n   = r_rep + 16'd1;
                        end
`else
                        w_state_n = ST_PRESSED;
`endif
                    end
                end
                ST_RELEASE: begin
                    if (r_sync2 == ROW_NONE) begin
                        w_cnt_n = w_cnt_inc;
                        if (w_cnt_inc >= DB_LIMIT) begin
                            w_down_n  = 1'b0;
                            w_state_n = ST_SCAN;
                            w_col_n   = rotate_col(r_col);
                            w_cnt_n   = 8'd0;
                        end else begin
                            w_state_n = ST_RELEASE;
                        end
                    end else begin
                        w_state_n = ST_PRESSED;
                    end
                end
                default: begin
                    w_state_n = ST_SCAN;
                    w_col_n   = COL_RESET;
                    w_cnt_n   = 8'd0;
                end
            endcase
        end else begin
            w_state_n = r_state;
        end
        // The row part comes from the live sample, which equals the latched pattern here.
        if (w_accept) begin
            w_code_n  = {low_idx(r_sync2), low_idx(r_col)};
            w_valid_n = 1'b1;
            w_down_n  = 1'b1;
`ifdef KEYPAD_REPEAT_EN
            w_rep_n   = 16'd0;
`endif
        end else begin
            w_code_n = w_code_n;
        end
    end

    // Scanner state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_SCAN;
            r_col     <= COL_RESET;
            r_pattern <= ROW_NONE;
            r_cnt     <= 8'd0;
            r_code    <= '0;
            r_valid   <= 1'b0;
            r_down    <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            r_rep     <= 16'd0;
`endif
        end else begin
            r_state   <= w_state_n;
            r_col     <= w_col_n;
            r_pattern <= w_pattern_n;
            r_cnt     <= w_cnt_n;
            r_code    <= w_code_n;
            r_valid   <= w_valid_n;
            r_down    <= w_down_n;
`ifdef KEYPAD_REPEAT_EN
            r_rep     <= w_rep_n;
`endif
        end
    end

    assign col       = r_col;
    assign key_code  = r_code;
    assign key_valid = r_valid;
    assign key_down  = r_down;

endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan (SCAN_DIV=4, DEBOUNCE_TICKS=3, REPEAT_TICKS=5).
// A pressed-key mask models the matrix; ticks fall on clock edges 4, 8, 12, ...
module tb_keypad_scan;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_down;
    logic [15:0] key_mask = 16'h0000;
    int          checks = 0;
    int          errors = 0;
    int          cyc;
    int          strobes;

    keypad_scan #(.SCAN_DIV(4), .DEBOUNCE_TICKS(3), .REPEAT_TICKS(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .row       (row),
        .col       (col),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_down  (key_down)
    );

    always #5 clk = ~clk;

    // Matrix model: a pressed key pulls its row low while its column is driven low.
    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (key_mask[r*4+c] && !col[c]) row[r] = 1'b0;
            end
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)         strobes <= 0;
        else if (key_valid) strobes <= strobes + 1;
    end

    // Returns on the falling edge that follows clock edge k after reset release.
    task automatic at_edge(input int k);
        int guard = 0;
        while (cyc < k && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        if (cyc != k) begin
            errors++;
            $display("FAIL at_edge: cyc=%0d required %0d", cyc, k);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        key_mask = 16'h0000;
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (col !== 4'b1110) begin errors++; $display("FAIL reset_col: got %b required 1110", col); end
        checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b required 0", key_valid); end
        checks++; if (key_down !== 1'b0) begin errors++; $display("FAIL reset_down: got %b required 0", key_down); end
        checks++; if (key_code !== 4'd0) begin errors++; $display("FAIL reset_code: got %0d required 0", key_code); end
        @(negedge clk);
        rst_n = 1'b1;
        at_edge(3);
        checks++; if (col !== 4'b1110) begin errors++; $display("FAIL idle_col_e3: got %b required 1110", col); end
        at_edge(4);
        checks++; if (col !== 4'b1101) begin errors++; $display("FAIL idle_col_e4: got %b required 1101", col); end
        at_edge(8);
        checks++; if (col !== 4'b1011) begin errors++; $display("FAIL idle_col_e8: got %b required 1011", col); end
        at_edge(12);
        checks++; if (col !== 4'b0111) begin errors++; $display("FAIL idle_col_e12: got %b required 0111", col); end
        at_edge(16);
        checks++; if (col !== 4'b1110) begin errors++; $display("FAIL idle_col_e16: got %b required 1110", col); end
        at_edge(20);
        checks++; if (strobes !== 0) begin errors++; $display("FAIL idle_strobes: got %0d required 0", strobes); end
    endtask

    task automatic test_clean_press();
        key_mask = 16'h0200;
        do_reset();
        at_edge(15);
        checks++; if (key_valid !== 1'b0 || key_down !== 1'b0) begin errors++; $display("FAIL press_early: valid=%b down=%b required 0/0", key_valid, key_down); end
        checks++; if (col !== 4'b1101) begin errors++; $display("FAIL press_col_frozen: got %b required 1101", col); end
        at_edge(16);
        checks++; if (key_valid !== 1'b1) begin errors++; $display("FAIL press_valid: got %b required 1", key_valid); end
        checks++; if (key_code !== 4'd9) begin errors++; $display("FAIL press_code: got %0d required 9", key_code); end
        checks++; if (key_down !== 1'b1) begin errors++; $display("FAIL press_down: got %b required 1", key_down); end
        at_edge(17);
        checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL press_pulse_width: got %b required 0", key_valid); end
        at_edge(40);
        checks++; if (strobes !== 1 || col !== 4'b1101) begin errors++; $display("FAIL press_hold: strobes=%0d col=%b required 1/1101", strobes, col); end
        key_mask = 16'h0000;
        at_edge(51);
        checks++; if (key_down !== 1'b1) begin errors++; $display("FAIL release_early: got %b required 1", key_down); end
        at_edge(52);
        checks++; if (key_down !== 1'b0) begin errors++; $display("FAIL release_down: got %b required 0", key_down); end
        checks++; if (col !== 4'b1011) begin errors++; $display("FAIL release_col: got %b required 1011", col); end
        at_edge(56);
        checks++; if (col !== 4'b0111 || strobes !== 1) begin errors++; $display("FAIL release_resume: col=%b strobes=%0d required 0111/1", col, strobes); end
    endtask

    task automatic test_bounce();
        key_mask = 16'h0001;
        do_reset();
        at_edge(8);
        checks++; if (col !== 4'b1110 || key_down !== 1'b0) begin errors++; $display("FAIL bounce_debouncing: col=%b down=%b required 1110/0", col, key_down); end
        key_mask = 16'h0000;
        at_edge(12);
        checks++; if (col !== 4'b1101 || key_down !== 1'b0) begin errors++; $display("FAIL bounce_abort: col=%b down=%b required 1101/0", col, key_down); end
        key_mask = 16'h0001;
        at_edge(35);
        checks++; if (strobes !== 0 || key_valid !== 1'b0) begin errors++; $display("FAIL bounce_no_strobe: strobes=%0d valid=%b required 0/0", strobes, key_valid); end
        at_edge(36);
        checks++; if (key_valid !== 1'b1 || key_code !== 4'd0 || key_down !== 1'b1) begin errors++; $display("FAIL bounce_accept: valid=%b code=%0d down=%b required 1/0/1", key_valid, key_code, key_down); end
        at_edge(40);
        key_mask = 16'h0000;
        at_edge(44);
        key_mask = 16'h0001;
        at_edge(48);
        key_mask = 16'h0000;
        at_edge(59);
        checks++; if (key_down !== 1'b1 || strobes !== 1) begin errors++; $display("FAIL release_bounce_hold: down=%b strobes=%0d required 1/1", key_down, strobes); end
        at_edge(60);
        checks++; if (key_down !== 1'b0 || col !== 4'b1101) begin errors++; $display("FAIL release_bounce_end: down=%b col=%b required 0/1101", key_down, col); end
    endtask

    task automatic test_multi_ghost();
        key_mask = 16'h0808;
        do_reset();
        at_edge(24);
        checks++; if (key_valid !== 1'b1 || key_code !== 4'd3) begin errors++; $display("FAIL multi_code: valid=%b code=%0d required 1/3", key_valid, key_code); end
        key_mask = 16'h08C8;
        at_edge(48);
        checks++; if (strobes !== 1 || key_down !== 1'b1 || col !== 4'b0111) begin errors++; $display("FAIL ghost_ignored: strobes=%0d down=%b col=%b required 1/1/0111", strobes, key_down, col); end
        key_mask = 16'h0000;
        at_edge(60);
        checks++; if (key_down !== 1'b0 || col !== 4'b1110 || strobes !== 1) begin errors++; $display("FAIL ghost_release: down=%b col=%b strobes=%0d required 0/1110/1", key_down, col, strobes); end
    endtask

    task automatic test_reset_mid_press();
        key_mask = 16'h0200;
        do_reset();
        at_edge(20);
        checks++; if (key_down !== 1'b1) begin errors++; $display("FAIL midreset_pre: down=%b required 1", key_down); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (key_down !== 1'b0 || col !== 4'b1110) begin errors++; $display("FAIL midreset_async: down=%b col=%b required 0/1110", key_down, col); end
        checks++; if (key_code !== 4'd0 || key_valid !== 1'b0) begin errors++; $display("FAIL midreset_outputs: code=%0d valid=%b required 0/0", key_code, key_valid); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        at_edge(16);
        checks++; if (key_valid !== 1'b1 || key_code !== 4'd9) begin errors++; $display("FAIL midreset_restrobe: valid=%b code=%0d required 1/9", key_valid, key_code); end
        at_edge(17);
        checks++; if (strobes !== 1) begin errors++; $display("FAIL midreset_count: strobes=%0d required 1", strobes); end
        key_mask = 16'h0000;
    endtask

    task automatic test_repeat();
        key_mask = 16'h0040;
        do_reset();
        at_edge(20);
        checks++; if (key_valid !== 1'b1 || key_code !== 4'd6) begin errors++; $display("FAIL repeat_first: valid=%b code=%0d required 1/6", key_valid, key_code); end
`ifdef KEYPAD_REPEAT_EN
        at_edge(39);
        checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL repeat_early: valid=%b required 0", key_valid); end
        at_edge(40);
        checks++; if (key_valid !== 1'b1 || key_code !== 4'd6) begin errors++; $display("FAIL repeat_second: valid=%b code=%0d required 1/6", key_valid, key_code); end
        at_edge(60);
        checks++; if (key_valid !== 1'b1 || key_code !== 4'd6) begin errors++; $display("FAIL repeat_third: valid=%b code=%0d required 1/6", key_valid, key_code); end
        at_edge(61);
        checks++; if (strobes !== 3) begin errors++; $display("FAIL repeat_count: strobes=%0d required 3", strobes); end
`else
        at_edge(61);
        checks++; if (strobes !== 1 || key_down !== 1'b1) begin errors++; $display("FAIL single_strobe: strobes=%0d down=%b required 1/1", strobes, key_down); end
`endif
        key_mask = 16'h0000;
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_multi_ghost();
        test_reset_mid_press();
        test_repeat();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
